// File: rtl/act_output_writer.sv
// act_output_writer
// Downstream end of the activation stage. Takes one activated row per
// qualified cycle and writes it into the output BRAM at base + k*stride,
// with per-lane write enables taken from the validity mask. Completion is
// flagged once the programmed number of rows has been written.
//
// Optional build macro: ACT_WRITER_OVERRUN_EN
//   When defined, adds a sticky 'overrun' output that flags rows arriving
//   while the writer is not armed (those rows are always dropped).
module act_output_writer #(
  parameter int MAT_MUL_SIZE = 4,
  parameter int DWIDTH       = 8,
  parameter int AWIDTH       = 10,
  parameter int RWIDTH       = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [AWIDTH-1:0]              base_addr,
  input  logic [AWIDTH-1:0]              addr_stride,
  input  logic [RWIDTH-1:0]              num_rows,
  input  logic                           in_data_available,
  input  logic [MAT_MUL_SIZE*DWIDTH-1:0] in_data,
  input  logic [MAT_MUL_SIZE-1:0]        validity_mask,
  output logic [AWIDTH-1:0]              bram_addr,
  output logic [MAT_MUL_SIZE*DWIDTH-1:0] bram_wdata,
  output logic [MAT_MUL_SIZE-1:0]        bram_we,
  output logic                           busy,
  output logic                           done,
`ifdef ACT_WRITER_OVERRUN_EN
  output logic                           overrun,
`endif
  output logic [RWIDTH-1:0]              rows_written
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [AWIDTH-1:0]              cur_addr;
  logic [AWIDTH-1:0]              stride_q;
  logic [RWIDTH-1:0]              rows_left;
  logic [MAT_MUL_SIZE*DWIDTH-1:0] masked_data;

  // A start is honoured only outside ARMED; rows are taken only inside it.
  logic load;
  logic accept;

  assign load   = start && (state_q != ARMED);
  assign accept = in_data_available && (state_q == ARMED);

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: state and datapath registers use non-blocking assignments so every
    // flop samples the pre-edge values, independent of block ordering.
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic: arm on start, finish on the last accepted row.
  always_comb begin
    // NOTE: default assignment first so no path leaves state_d unassigned,
    // which would otherwise infer a latch.
    state_d = state_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) state_d = (num_rows != '0) ? ARMED : DONE;
      end
      ARMED: begin
        if (in_data_available && (rows_left == RWIDTH'(1))) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Status outputs decoded directly from the state.
  always_comb begin
    busy = (state_q == ARMED);
    done = (state_q == DONE);
  end

  // Zero the data of lanes whose mask bit is clear (lane i+1 lives at bit i*DWIDTH).
  always_comb begin
    masked_data = '0;
    for (int i = 0; i < MAT_MUL_SIZE; i++) begin
      if (validity_mask[i]) masked_data[i*DWIDTH +: DWIDTH] = in_data[i*DWIDTH +: DWIDTH];
    end
  end

  // Job configuration, address generation and the registered BRAM write port.
  always_ff @(posedge clk) begin
    if (reset) begin
      cur_addr     <= '0;
      stride_q     <= '0;
      rows_left    <= '0;
      rows_written <= '0;
      bram_addr    <= '0;
      bram_wdata   <= '0;
      bram_we      <= '0;
    end else begin
      // Write enable is a one-cycle strobe; address and data hold otherwise.
      bram_we <= '0;
      if (load) begin
        cur_addr     <= base_addr;
        stride_q     <= addr_stride;
        rows_left    <= num_rows;
        rows_written <= '0;
      end else if (accept) begin
        bram_addr    <= cur_addr;
        bram_wdata   <= masked_data;
        bram_we      <= validity_mask;
        cur_addr     <= cur_addr + stride_q;  // wraps modulo 2^AWIDTH
        rows_left    <= rows_left - RWIDTH'(1);
        rows_written <= rows_written + RWIDTH'(1);
      end
    end
  end

`ifdef ACT_WRITER_OVERRUN_EN
  // Sticky flag for rows that arrive while not armed; cleared by an accepted start.
  always_ff @(posedge clk) begin
    if (reset)                                       overrun <= 1'b0;
    else if (load)                                   overrun <= 1'b0;
    else if (in_data_available && state_q != ARMED)  overrun <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_act_output_writer.sv
// Self-checking bench for act_output_writer. A job-level model predicts the
// registered outputs each cycle; directed literal checks pin the model.
module tb_act_output_writer;

  localparam int MM = 4;
  localparam int DW = 8;
  localparam int AW = 10;
  localparam int RW = 8;

  logic              clk;
  logic              reset;
  logic              start;
  logic [AW-1:0]     base_addr;
  logic [AW-1:0]     addr_stride;
  logic [RW-1:0]     num_rows;
  logic              in_data_available;
  logic [MM*DW-1:0]  in_data;
  logic [MM-1:0]     validity_mask;
  logic [AW-1:0]     bram_addr;
  logic [MM*DW-1:0]  bram_wdata;
  logic [MM-1:0]     bram_we;
  logic              busy;
  logic              done;
  logic [RW-1:0]     rows_written;
`ifdef ACT_WRITER_OVERRUN_EN
  logic              overrun;
`endif

  act_output_writer #(
    .MAT_MUL_SIZE(MM), .DWIDTH(DW), .AWIDTH(AW), .RWIDTH(RW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .base_addr(base_addr),
    .addr_stride(addr_stride),
    .num_rows(num_rows),
    .in_data_available(in_data_available),
    .in_data(in_data),
    .validity_mask(validity_mask),
    .bram_addr(bram_addr),
    .bram_wdata(bram_wdata),
    .bram_we(bram_we),
    .busy(busy),
    .done(done),
`ifdef ACT_WRITER_OVERRUN_EN
    .overrun(overrun),
`endif
    .rows_written(rows_written)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- job-level model ----------------
  // A job is (base, stride, total); row k of the job goes to (base + k*stride) mod 2^AW.
  bit               m_active;
  bit               m_done;
  int               m_base, m_stride, m_total, m_k;
  logic [AW-1:0]    e_addr;
  logic [MM*DW-1:0] e_wdata;
  logic [MM-1:0]    e_we;
  bit               e_over;

  task automatic model_step();
    if (reset) begin
      m_active = 0; m_done = 0; m_base = 0; m_stride = 0; m_total = 0; m_k = 0;
      e_addr = '0; e_wdata = '0; e_we = '0; e_over = 0;
    end else begin
      e_we = '0;
      if (m_active) begin
        if (in_data_available) begin
          e_addr = AW'((m_base + m_k * m_stride) % (1 << AW));
          e_we   = validity_mask;
          for (int i = 0; i < MM; i++)
            e_wdata[i*DW +: DW] = validity_mask[i] ? in_data[i*DW +: DW] : '0;
          m_k++;
          if (m_k == m_total) begin
            m_active = 0;
            m_done   = 1;
          end
        end
      end else if (start) begin
        m_base = int'(base_addr); m_stride = int'(addr_stride); m_total = int'(num_rows);
        m_k = 0; e_over = 0;
        if (num_rows == '0) m_done = 1;
        else begin m_active = 1; m_done = 0; end
      end else if (in_data_available) begin
        e_over = 1;
      end
    end
  endtask

  // Single compare process: advance the model at the edge, compare just after it.
  initial begin
    forever begin
      @(posedge clk);
      model_step();
      #2;
      check("bram_we", 32'(bram_we), 32'(e_we));
      check("bram_addr", 32'(bram_addr), 32'(e_addr));
      check("bram_wdata", bram_wdata, e_wdata);
      check("busy", 32'(busy), 32'(m_active));
      check("done", 32'(done), 32'(m_done));
      check("rows_written", 32'(rows_written), 32'(m_k));
`ifdef ACT_WRITER_OVERRUN_EN
      check("overrun", 32'(overrun), 32'(e_over));
`endif
    end
  end

  // Apply one cycle of inputs starting at a falling edge; returns at the next one.
  task automatic cyc(input logic st, input logic dv, input logic [31:0] d, input logic [3:0] m);
    start = st; in_data_available = dv; in_data = d; validity_mask = m;
    @(negedge clk);
  endtask

  task automatic cfg(input logic [AW-1:0] b, input logic [AW-1:0] s, input logic [RW-1:0] n);
    base_addr = b; addr_stride = s; num_rows = n;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 0; in_data_available = 0; in_data = '0; validity_mask = '0;
    cfg('0, '0, '0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("reset_we", 32'(bram_we), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_done", 32'(done), 32'h0);
    check("reset_rows", 32'(rows_written), 32'h0);

    // Basic job: 4 back-to-back rows at 0x010..0x013, then an extra row that must drop.
    cfg(10'h010, 10'd1, 8'd4);
    cyc(1, 0, 32'h0, 4'h0);
    check("basic_busy", 32'(busy), 32'h1);
    cyc(0, 1, 32'h11223344, 4'hF);
    check("basic_addr0", 32'(bram_addr), 32'h010);
    check("basic_data0", bram_wdata, 32'h11223344);
    cyc(0, 1, 32'h55667788, 4'hF);
    cyc(0, 1, 32'h99AABBCC, 4'hF);
    cyc(0, 1, 32'hDDEEFF00, 4'hF);
    check("basic_addr3", 32'(bram_addr), 32'h013);
    check("basic_we3", 32'(bram_we), 32'hF);
    check("basic_done", 32'(done), 32'h1);
    check("basic_rows", 32'(rows_written), 32'd4);
    cyc(0, 1, 32'hCAFEBABE, 4'hF);
    check("extra_row_we", 32'(bram_we), 32'h0);
    check("extra_row_rows", 32'(rows_written), 32'd4);

    // Masked lanes and stride 4.
    cfg(10'h000, 10'd4, 8'd2);
    cyc(1, 0, 32'h0, 4'h0);
    cyc(0, 1, 32'hAABBCCDD, 4'b0101);
    check("mask_we", 32'(bram_we), 32'h5);
    check("mask_data", bram_wdata, 32'h00BB00DD);
    check("mask_addr0", 32'(bram_addr), 32'h000);
    cyc(0, 1, 32'h01020304, 4'b1010);
    check("mask_addr1", 32'(bram_addr), 32'h004);
    check("mask_data1", bram_wdata, 32'h01000300);

    // Address wrap with idle gaps between rows.
    cfg(10'h3FE, 10'd1, 8'd3);
    cyc(1, 0, 32'h0, 4'h0);
    cyc(0, 1, 32'h0A0A0A0A, 4'hF);
    check("wrap_addr0", 32'(bram_addr), 32'h3FE);
    cyc(0, 0, 32'h0, 4'h0);
    check("gap_we", 32'(bram_we), 32'h0);
    cyc(0, 1, 32'h0B0B0B0B, 4'hF);
    check("wrap_addr1", 32'(bram_addr), 32'h3FF);
    cyc(0, 0, 32'h0, 4'h0);
    cyc(0, 0, 32'h0, 4'h0);
    cyc(0, 1, 32'h0C0C0C0C, 4'hF);
    check("wrap_addr2", 32'(bram_addr), 32'h000);
    check("wrap_done", 32'(done), 32'h1);

    // Zero-row job, then a dropped row in DONE, then a 2-row job whose start carries a row.
    cfg(10'h050, 10'd1, 8'd0);
    cyc(1, 0, 32'h0, 4'h0);
    check("zero_done", 32'(done), 32'h1);
    check("zero_busy", 32'(busy), 32'h0);
    cyc(0, 1, 32'h12345678, 4'hF);
    check("drop_done_we", 32'(bram_we), 32'h0);
`ifdef ACT_WRITER_OVERRUN_EN
    check("drop_overrun", 32'(overrun), 32'h1);
`endif
    cfg(10'h060, 10'd2, 8'd2);
    cyc(1, 1, 32'hFFFFFFFF, 4'hF);
    check("restart_done", 32'(done), 32'h0);
    check("restart_we", 32'(bram_we), 32'h0);
    cyc(0, 1, 32'h21212121, 4'hF);
    check("restart_addr0", 32'(bram_addr), 32'h060);
    cyc(0, 1, 32'h31313131, 4'hF);
    check("restart_addr1", 32'(bram_addr), 32'h062);
    check("restart_rows", 32'(rows_written), 32'd2);

    // Start while armed is ignored.
    cfg(10'h100, 10'd2, 8'd3);
    cyc(1, 0, 32'h0, 4'h0);
    cyc(0, 1, 32'h41414141, 4'hF);
    cfg(10'h200, 10'd5, 8'd9);
    cyc(1, 1, 32'h42424242, 4'hF);
    check("ign_addr1", 32'(bram_addr), 32'h102);
    cyc(0, 1, 32'h43434343, 4'hF);
    check("ign_addr2", 32'(bram_addr), 32'h104);
    check("ign_done", 32'(done), 32'h1);

    // Reset after 2 of 4 rows aborts the job.
    cfg(10'h020, 10'd1, 8'd4);
    cyc(1, 0, 32'h0, 4'h0);
    cyc(0, 1, 32'h51515151, 4'hF);
    cyc(0, 1, 32'h52525252, 4'hF);
    reset = 1'b1;
    cyc(0, 0, 32'h0, 4'h0);
    reset = 1'b0;
    check("rst_addr", 32'(bram_addr), 32'h0);
    check("rst_data", bram_wdata, 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_rows", 32'(rows_written), 32'h0);
    cyc(0, 1, 32'h53535353, 4'hF);
    cyc(0, 1, 32'h54545454, 4'hF);
    check("rst_drop_we", 32'(bram_we), 32'h0);
    cfg(10'h030, 10'd1, 8'd1);
    cyc(1, 0, 32'h0, 4'h0);
    cyc(0, 1, 32'h61626364, 4'b0011);
    check("post_rst_addr", 32'(bram_addr), 32'h030);
    check("post_rst_data", bram_wdata, 32'h00006364);
    check("post_rst_done", 32'(done), 32'h1);
    cyc(0, 0, 32'h0, 4'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
